num_rom_arb: RTL

NUM_ROM_ARB -- requirements
Module: num_rom_arb

---
 rtl/num_rom_arb_pkg.sv | 19 +
 rtl/num_rom_rsp_pipe.sv | 38 +++
 rtl/num_rom_arb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/num_rom_arb_pkg.sv
// Shared types and defaults for the num_rom two-port read arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package num_rom_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 24;

    // Arbiter ownership state: free, or locked to one requester for a burst
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Requester identity carried alongside each read in flight
    typedef logic req_id_t;

endpackage

// File: rtl/num_rom_rsp_pipe.sv
// Delay line carrying valid + requester id alongside the num_rom read.
// Latency: DEPTH cycles from in_vld to out_vld.
// Backpressure: none; one entry may enter every cycle and nothing stalls.
module num_rom_rsp_pipe
    import num_rom_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    tb_rst,
    input  logic    in_vld,
    input  req_id_t in_id,
    output logic    out_vld,
    output req_id_t out_id
);

    logic [DEPTH-1:0]    vld_q;
    req_id_t [DEPTH-1:0] id_q;

    // Shift the tag one stage per cycle; reset empties every stage
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q[0] <= in_vld;
            id_q[0]  <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_id  = id_q[DEPTH-1];

endmodule

// File: rtl/num_rom_arb.sv
// Two-requester burst arbiter in front of the single num_rom read port.
// Latency: address combinational in the accept cycle; rspN_valid ROM_LAT cycles later.
// Backpressure: reqN_ready low while the other port owns a burst or loses IDLE arbitration.
// Optional statistics counters are built when NUM_ROM_ARB_STATS_EN is defined.
module num_rom_arb
    import num_rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROM_LAT    = 1    // 1 = unregistered ROM output, 2 = output-registered
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_last,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_last,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data
`ifdef NUM_ROM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_beats0,
    output logic [15:0]           stat_beats1,
    output logic [15:0]           stat_stall
`endif
);

    arb_state_t            state_q, state_d;
    req_id_t               ptr_q, ptr_d;     // port favoured when both ask in IDLE
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  acc0, acc1, acc_vld;
    req_id_t               acc_id;
    logic                  pipe_vld;
    req_id_t               pipe_id;

    // Grant in IDLE (same cycle), lock to the owner until its last beat is accepted
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid && (!req1_valid || ptr_q == 1'b0)) begin
                    req0_ready = 1'b1;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                end
            end
            OWN0:    req0_ready = 1'b1;
            OWN1:    req1_ready = 1'b1;
            default: state_d = IDLE;
        endcase
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        if (acc0) begin
            state_d = req0_last ? IDLE : OWN0;
            if (req0_last) ptr_d = 1'b1;
        end else if (acc1) begin
            state_d = req1_last ? IDLE : OWN1;
            if (req1_last) ptr_d = 1'b0;
        end
    end

    assign acc_vld = acc0 | acc1;
    assign acc_id  = acc1;
    assign rom_addr = acc1 ? req1_addr : (acc0 ? req0_addr : addr_q);

    // State, round-robin pointer and held address registers
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (acc_vld) addr_q <= rom_addr;
        end
    end

    num_rom_rsp_pipe #(
        .DEPTH (ROM_LAT)
    ) u_rsp_pipe (
        .clk     (clk),
        .tb_rst  (tb_rst),
        .in_vld  (acc_vld),
        .in_id   (acc_id),
        .out_vld (pipe_vld),
        .out_id  (pipe_id)
    );

    assign rsp0_valid = pipe_vld & (pipe_id == 1'b0);
    assign rsp1_valid = pipe_vld & (pipe_id == 1'b1);
    assign rsp_data   = rom_rd_data;

`ifdef NUM_ROM_ARB_STATS_EN
    logic stall;
    assign stall = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

    // Saturating accepted-beat and stall-cycle counters
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            stat_beats0 <= '0;
            stat_beats1 <= '0;
            stat_stall  <= '0;
        end else begin
            if (acc0 && stat_beats0 != 16'hFFFF) stat_beats0 <= stat_beats0 + 16'd1;
            if (acc1 && stat_beats1 != 16'hFFFF) stat_beats1 <= stat_beats1 + 16'd1;
            if (stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
        end
    end
`else
    // No statistics logic in this build.
`endif

endmodule
